// File: rtl/three_wire_responder_pkg.sv
// three_wire_responder_pkg: shared frame geometry, slot indices and FSM state encoding
package three_wire_responder_pkg;
  localparam int FRAME_LEN = 16;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] SLOT_RW = 5'd6;
  localparam logic [CNT_W-1:0] SLOT_ACK = 5'd7;
  localparam logic [CNT_W-1:0] SLOT_DATA_FIRST = 5'd8;
  localparam logic [CNT_W-1:0] LAST_SLOT = 5'd15;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_ACK, ST_DATA, ST_DONE} state_e;
endpackage

// File: rtl/three_wire_sync.sv
// three_wire_sync: multi-stage input synchronizer with rise/fall detection on the synchronized level
module three_wire_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q;
  // next value of the chain: shift the raw input in at the bottom
  always_comb begin
    sync_d = STAGES'({sync_q, d});
    q = sync_q[STAGES-1];
    rise = q & ~prev_q;
    fall = ~q & prev_q;
  end
  // chain plus one delayed copy of the synchronized level for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= q;
    end
endmodule

// File: rtl/three_wire_responder.sv
// three_wire_responder: 3-wire serial register-file slave with ACK, reads, writes and abort detection
module three_wire_responder
  import three_wire_responder_pkg::*;
#(
  parameter int NREGS = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSCEN,
  input  logic              iSCLK,
  inout  wire               SDA,
  output logic              oWR,
  output logic [ADDR_W-1:0] oWADDR,
  output logic [DATA_W-1:0] oWDATA,
  input  logic [ADDR_W-1:0] iHADDR,
  output logic [DATA_W-1:0] oHDATA,
  output logic              oBUSY,
  output logic              oERR
);
  logic scen_s, scen_rise, scen_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic sda_s, sda_rise, sda_fall;
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q, rd_byte;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic rw_q, oe_q, out_q, wr_q, err_q, busy_q;
  logic valid, wr_go, oe_d, out_d, hsel;
  wire unused_ok = &{1'b0, sclk_s, sda_rise, sda_fall, shreg_q[FRAME_LEN-1]};

  // scen idles at 0 after reset so a frame still open across reset needs a fresh falling edge
  three_wire_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_scen (
    .clk(iCLK), .rst_n(iRST), .d(iSCEN), .q(scen_s), .rise(scen_rise), .fall(scen_fall));
  three_wire_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(iCLK), .rst_n(iRST), .d(iSCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  three_wire_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
    .clk(iCLK), .rst_n(iRST), .d(SDA), .q(sda_s), .rise(sda_rise), .fall(sda_fall));

  // drive is dropped combinationally as soon as synchronized scen goes high
  assign SDA = (oe_q && !scen_s) ? out_q : 1'bz;
  assign oWR = wr_q;
  assign oERR = err_q;
  assign oBUSY = busy_q;
  assign oWADDR = waddr_q;
  assign oWDATA = wdata_q;

  // shift-in value, address check, write commit and next SDA drive for the upcoming slot
  always_comb begin
    shreg_d = {shreg_q[FRAME_LEN-2:0], sda_s};
    valid = int'(addr_q) < NREGS;
    rd_byte = regs_q[valid ? addr_q : '0];
    wr_go = state_q == ST_DATA && !scen_rise && sclk_rise && cnt_q == LAST_SLOT && valid && !rw_q;
    oe_d = cnt_q == SLOT_ACK ? valid : (cnt_q >= SLOT_DATA_FIRST && cnt_q <= LAST_SLOT && valid && rw_q);
    out_d = cnt_q == SLOT_ACK ? 1'b0 : rd_byte[~cnt_q[2:0]];
    hsel = int'(iHADDR) < NREGS;
    oHDATA = hsel ? regs_q[hsel ? iHADDR : '0] : '0;
  end

  // frame FSM: slot counting, shifting, SDA drive timing, write/abort pulses
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      shreg_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      out_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (scen_fall) begin
          state_q <= ST_ADDR;
          cnt_q <= '0;
          shreg_q <= '0;
          busy_q <= 1'b1;
        end
      end else if (scen_rise) begin
        state_q <= ST_IDLE;
        oe_q <= 1'b0;
        busy_q <= 1'b0;
        err_q <= state_q != ST_DONE;
      end else if (state_q != ST_DONE && sclk_rise) begin
        shreg_q <= shreg_d;
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == SLOT_RW) begin
          addr_q <= shreg_q[ADDR_W-1:0];
          rw_q <= sda_s;
          state_q <= ST_ACK;
        end
        if (cnt_q == SLOT_ACK) state_q <= ST_DATA;
        if (cnt_q == LAST_SLOT) state_q <= ST_DONE;
        if (wr_go) begin
          wr_q <= 1'b1;
          waddr_q <= addr_q;
          wdata_q <= shreg_d[DATA_W-1:0];
        end
      end else if (sclk_fall) begin
        oe_q <= state_q != ST_DONE && oe_d;
        out_q <= out_d;
      end
    end

  // register file, cleared by reset, written only on a committed valid write
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_go) begin
      regs_q[addr_q] <= shreg_d[DATA_W-1:0];
    end
endmodule

// File: tb/tb_three_wire_responder.sv
// tb_three_wire_responder: randomized serial master with a register-array reference model
module tb_three_wire_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scen = 1'b1;
  logic sclk = 1'b0;
  logic m_oe = 1'b0;
  logic m_out = 1'b0;
  logic [5:0] haddr = '0;
  wire sda;
  logic wr, err, busy;
  logic [5:0] waddr;
  logic [7:0] wdata, hdata;
  logic [7:0] mem [64];
  logic [15:0] rx;
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int rst_slot = -1;

  assign sda = m_oe ? m_out : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;

  three_wire_responder #(.NREGS(40), .SYNC_STAGES(2)) dut (
    .iCLK(clk), .iRST(rst_n), .iSCEN(scen), .iSCLK(sclk), .SDA(sda),
    .oWR(wr), .oWADDR(waddr), .oWDATA(wdata), .iHADDR(haddr), .oHDATA(hdata),
    .oBUSY(busy), .oERR(err));

  always @(negedge clk) begin
    if (wr) wr_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one master transaction with nrise rising SCLK edges; 16 is a complete frame
  task automatic frame(input logic [5:0] a, input logic rw, input logic [7:0] d, input int nrise);
    logic [15:0] bits;
    bit valid, commit;
    int w0, e0;
    bits = {a, rw, 1'b1, d};
    valid = a < 6'd40;
    commit = nrise >= 16 && valid && !rw;
    w0 = wr_cnt;
    e0 = err_cnt;
    rx = '1;
    scen = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      repeat (6) @(negedge clk);
      m_oe = (i < 7) || (i >= 8 && i < 16 && !rw);
      m_out = bits[(15 - i) & 15];
      repeat (2) @(negedge clk);
      if (i < 16) rx[15 - i] = sda;
      if (i == 3) check("busy_mid", busy, 1);
      if (i == rst_slot) begin
        check("drive_before_rst", sda, 0);
        rst_n = 1'b0;
        #1;
        check("sda_on_rst", sda, 1);
        haddr = a;
        repeat (2) @(negedge clk);
        check("hdata_on_rst", hdata, 0);
        check("busy_on_rst", busy, 0);
        m_oe = 1'b0;
        scen = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_err_on_rst", err_cnt - e0, 0);
        check("no_wr_on_rst", wr_cnt - w0, 0);
        for (int k = 0; k < 64; k++) mem[k] = '0;
        rst_slot = -1;
        return;
      end
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      m_oe = 1'b0;
    end
    repeat (10) @(negedge clk);
    if (nrise >= 16) check("sda_after_frame", sda, 1);
    scen = 1'b1;
    repeat (10) @(negedge clk);
    check("sda_idle", sda, 1);
    check("busy_idle", busy, 0);
    if (nrise >= 8) check("ack", rx[8], valid ? 0 : 1);
    if (nrise >= 16 && rw) check("rdata", rx[7:0], valid ? mem[a] : 8'hFF);
    check("wr_pulses", wr_cnt - w0, commit ? 1 : 0);
    check("err_pulses", err_cnt - e0, nrise < 16 ? 1 : 0);
    if (commit) begin
      mem[a] = d;
      check("waddr", waddr, a);
      check("wdata", wdata, d);
    end
    haddr = a;
    #1;
    check("hdata", hdata, valid ? mem[a] : 8'h00);
  endtask

  initial begin
    int r, n;
    logic [5:0] a;
    logic [7:0] d;
    for (int k = 0; k < 64; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_wr", wr, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_hdata", hdata, 0);
    check("rst_sda", sda, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    frame(6'h05, 1'b0, 8'hA5, 16);
    frame(6'h10, 1'b0, 8'h3C, 16);
    frame(6'h10, 1'b1, 8'h00, 16);
    frame(6'h30, 1'b0, 8'h5A, 16);
    frame(6'h12, 1'b0, 8'h11, 10);
    frame(6'h12, 1'b0, 8'h11, 16);
    frame(6'h12, 1'b1, 8'h00, 16);
    frame(6'h22, 1'b0, 8'hA6, 16);
    rst_slot = 12;
    frame(6'h22, 1'b1, 8'h00, 16);
    frame(6'h22, 1'b1, 8'h00, 16);
    frame(6'h01, 1'b0, 8'h7E, 20);
    frame(6'h01, 1'b1, 8'h00, 16);
    for (int t = 0; t < 60; t++) begin
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      n = r == 0 ? $urandom_range(1, 15) : r == 1 ? $urandom_range(17, 22) : 16;
      frame(a, 1'($urandom), d, n);
    end
    for (int t = 0; t < 20; t++) begin
      haddr = 6'($urandom_range(0, 63));
      #1;
      check("host_read", hdata, haddr < 6'd40 ? mem[haddr] : 8'h00);
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
